sprite_motion_sched: RTL and testbench

SPRITE_MOTION_SCHED -- requirements
Module: sprite_motion_sched

---
 rtl/sprite_motion_sched.sv | 181 ++++++++++++++++++
 tb/tb_sprite_motion_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_sched.sv
`default_nettype none
// ============================================================================
// sprite_motion_sched : per-frame sprite position sequencer, one sprite/cycle
// Revision 1.0
// ============================================================================
module sprite_motion_sched #(
  parameter int         NUM_SPRITES = 4,
  parameter logic [9:0] STEP        = 10'd1,
  parameter logic [9:0] SIZE        = 10'd16,
  parameter logic [9:0] X_MIN       = 10'd0,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] Y_MIN       = 10'd0,
  parameter logic [9:0] Y_MAX       = 10'd479
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic [7:0]                 keycode,
  output logic [10*NUM_SPRITES-1:0]  SpriteX,
  output logic [10*NUM_SPRITES-1:0]  SpriteY,
  output logic [9:0]                 SpriteS,
  output logic                       busy,
  output logic                       update_done,
  output logic                       overrun
);

  localparam int         IDX_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [9:0] NEG_STEP = ~STEP + 10'd1;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         key_q;
  logic               last_sprite;
  logic               upd_en;

  logic [10*NUM_SPRITES-1:0] mot_x_all;
  logic [10*NUM_SPRITES-1:0] mot_y_all;

  logic [9:0] cur_x, cur_y, cur_mx, cur_my;
  logic [9:0] key_mx, key_my;
  logic [9:0] fin_mx, fin_my;
  logic [9:0] new_x, new_y;
  logic       hi_x, lo_x, hi_y, lo_y;

  assign SpriteS     = SIZE;
  assign last_sprite = (idx == IDX_W'(NUM_SPRITES - 1));
  assign upd_en      = (state == UPDATE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    busy        = (state != IDLE);
    update_done = 1'b0;
    case (state)
      IDLE:    if (frame_start) state_next = UPDATE;
      UPDATE:  if (last_sprite) state_next = DONE;
      DONE: begin
        update_done = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx     <= '0;
      key_q   <= 8'h00;
      overrun <= 1'b0;
    end else begin
      if (state == IDLE && frame_start) begin
        key_q <= keycode;
        idx   <= '0;
      end else if (state == UPDATE && !last_sprite) begin
        idx <= idx + IDX_W'(1);
      end
      if (state != IDLE && frame_start) begin
        overrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared motion/bounds datapath for sprite idx
  // ---------------------------------------------------------------------------
  assign cur_x  = SpriteX[10*idx +: 10];
  assign cur_y  = SpriteY[10*idx +: 10];
  assign cur_mx = mot_x_all[10*idx +: 10];
  assign cur_my = mot_y_all[10*idx +: 10];

  always_comb begin
    key_mx = cur_mx;
    key_my = cur_my;
    if (idx == '0) begin
      case (key_q)
        KEY_W: begin key_mx = 10'd0;    key_my = NEG_STEP; end
        KEY_A: begin key_mx = NEG_STEP; key_my = 10'd0;    end
        KEY_S: begin key_mx = 10'd0;    key_my = STEP;     end
        KEY_D: begin key_mx = STEP;     key_my = 10'd0;    end
        default: ;
      endcase
    end
  end

  // 11-bit compares so pos+SIZE cannot wrap; lower bound never subtracts from pos
  assign hi_x = ({1'b0, cur_x} + {1'b0, SIZE}) >= {1'b0, X_MAX};
  assign lo_x = {1'b0, cur_x} <= ({1'b0, X_MIN} + {1'b0, SIZE});
  assign hi_y = ({1'b0, cur_y} + {1'b0, SIZE}) >= {1'b0, Y_MAX};
  assign lo_y = {1'b0, cur_y} <= ({1'b0, Y_MIN} + {1'b0, SIZE});

  always_comb begin
    fin_mx = key_mx;
    if (hi_x && !key_mx[9] && (key_mx != 10'd0)) fin_mx = NEG_STEP;
    if (lo_x && key_mx[9])                       fin_mx = STEP;
  end

  always_comb begin
    fin_my = key_my;
    if (hi_y && !key_my[9] && (key_my != 10'd0)) fin_my = NEG_STEP;
    if (lo_y && key_my[9])                       fin_my = STEP;
  end

  assign new_x = cur_x + fin_mx;
  assign new_y = cur_y + fin_my;

  // ---------------------------------------------------------------------------
  // Per-sprite position and motion registers
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_sprite
    localparam logic [9:0] RST_X  = 10'(80 + 160 * k);
    localparam logic [9:0] RST_Y  = 10'd240;
    localparam logic [9:0] RST_MV = (k == 0) ? 10'd0 : STEP;

    logic [9:0] pos_x, pos_y, mot_x, mot_y;
    logic       sel;

    assign sel = upd_en && (idx == IDX_W'(k));

    always_ff @(posedge Clk) begin
      if (Reset) begin
        pos_x <= RST_X;
        pos_y <= RST_Y;
        mot_x <= RST_MV;
        mot_y <= RST_MV;
      end else if (sel) begin
        pos_x <= new_x;
        pos_y <= new_y;
        mot_x <= fin_mx;
        mot_y <= fin_my;
      end
    end

    assign SpriteX[10*k +: 10]   = pos_x;
    assign SpriteY[10*k +: 10]   = pos_y;
    assign mot_x_all[10*k +: 10] = mot_x;
    assign mot_y_all[10*k +: 10] = mot_y;
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_sched.sv
`default_nettype none
// ============================================================================
// tb_sprite_motion_sched : scoreboard bench for sprite_motion_sched
// Revision 1.0
// ============================================================================
module tb_sprite_motion_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [7:0]    keycode;
  logic [10*N-1:0] sprite_x, sprite_y;
  logic [9:0]    sprite_s;
  logic          busy, update_done, overrun;

  always #5 clk = ~clk;

  sprite_motion_sched #(.NUM_SPRITES(N)) dut (
    .Clk         (clk),
    .Reset       (rst),
    .frame_start (frame_start),
    .keycode     (keycode),
    .SpriteX     (sprite_x),
    .SpriteY     (sprite_y),
    .SpriteS     (sprite_s),
    .busy        (busy),
    .update_done (update_done),
    .overrun     (overrun)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [10*N-1:0] x;
    logic [10*N-1:0] y;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int mx[N], my[N], vx[N], vy[N];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model of one pass, straight from the motion rules
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = 80 + 160 * k;
      my[k] = 240;
      vx[k] = (k == 0) ? 0 : 1;
      vy[k] = (k == 0) ? 0 : 1;
    end
  endtask

  task automatic model_pass(input logic [7:0] key);
    for (int k = 0; k < N; k++) begin
      if (k == 0) begin
        case (key)
          8'h1A: begin vx[k] = 0;  vy[k] = -1; end
          8'h04: begin vx[k] = -1; vy[k] = 0;  end
          8'h16: begin vx[k] = 0;  vy[k] = 1;  end
          8'h07: begin vx[k] = 1;  vy[k] = 0;  end
          default: ;
        endcase
      end
      if (my[k] + 16 >= 479 && vy[k] > 0) vy[k] = -1;
      if (my[k] <= 16 && vy[k] < 0)       vy[k] = 1;
      if (mx[k] + 16 >= 639 && vx[k] > 0) vx[k] = -1;
      if (mx[k] <= 16 && vx[k] < 0)       vx[k] = 1;
      mx[k] = (mx[k] + vx[k]) & 1023;
      my[k] = (my[k] + vy[k]) & 1023;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.x[10*k +: 10] = 10'(mx[k]);
      e.y[10*k +: 10] = 10'(my[k]);
    end
    sbq.push_back(e);
  endtask

  task automatic check_model_now(input string name);
    logic [10*N-1:0] ex, ey;
    for (int k = 0; k < N; k++) begin
      ex[10*k +: 10] = 10'(mx[k]);
      ey[10*k +: 10] = 10'(my[k]);
    end
    check({name, "_x"}, 40'(sprite_x), 40'(ex));
    check({name, "_y"}, 40'(sprite_y), 40'(ey));
  endtask

  // Monitor: compare on every completed pass
  always @(negedge clk) begin
    if (update_done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: update_done=1 expected 0 (no pass pending)");
      end else begin
        mon_e = sbq.pop_front();
        check("sb_x", 40'(sprite_x), 40'(mon_e.x));
        check("sb_y", 40'(sprite_y), 40'(mon_e.y));
      end
    end
  end

  task automatic run_pass(input logic [7:0] key);
    @(posedge clk); #1;
    keycode     = key;
    frame_start = 1'b1;
    model_pass(key);
    push_expected();
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (N + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; keycode = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_x",  40'(sprite_x), {10'd560, 10'd400, 10'd240, 10'd80});
    check("rst_y",  40'(sprite_y), {10'd240, 10'd240, 10'd240, 10'd240});
    check("rst_s",  40'(sprite_s), 40'd16);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_ovr",  40'(overrun), 40'd0);

    // Cycle-accurate first pass with D
    @(posedge clk); #1;
    keycode = 8'h07; frame_start = 1'b1;
    model_pass(8'h07);
    push_expected();
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("t%0d_busy", c), 40'(busy), (c <= 5) ? 40'd1 : 40'd0);
      check($sformatf("t%0d_done", c), 40'(update_done), (c == 5) ? 40'd1 : 40'd0);
      check($sformatf("t%0d_x0", c), 40'(sprite_x[9:0]), (c >= 2) ? 40'd81 : 40'd80);
      check($sformatf("t%0d_x1", c), 40'(sprite_x[19:10]), (c >= 3) ? 40'd241 : 40'd240);
      check($sformatf("t%0d_y1", c), 40'(sprite_y[19:10]), (c >= 3) ? 40'd241 : 40'd240);
    end

    // Hold D until the right-edge bounce
    for (int p = 1; p < 543; p++) run_pass(8'h07);
    check("x0_at_543", 40'(sprite_x[9:0]), 40'd623);
    run_pass(8'h07);
    check("x0_bounce", 40'(sprite_x[9:0]), 40'd622);
    check("y0_steady", 40'(sprite_y[9:0]), 40'd240);
    run_pass(8'h00);
    check("x0_keep_motion", 40'(sprite_x[9:0]), 40'd621);

    // Second frame_start inside a pass
    @(posedge clk); #1;
    keycode = 8'h00; frame_start = 1'b1;
    model_pass(8'h00);
    push_expected();
    @(posedge clk); #1 frame_start = 1'b0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(negedge clk);
    check("ovr_before", 40'(overrun), 40'd0);
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    check("ovr_set", 40'(overrun), 40'd1);
    repeat (5) @(posedge clk);
    #1;
    check("ovr_idle_busy", 40'(busy), 40'd0);
    check_model_now("ovr_single_adv");
    run_pass(8'h00);
    check("ovr_sticky", 40'(overrun), 40'd1);

    // Reset in the middle of a pass
    @(posedge clk); #1;
    keycode = 8'h07; frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rst_x", 40'(sprite_x), {10'd560, 10'd400, 10'd240, 10'd80});
    check("mid_rst_y", 40'(sprite_y), {10'd240, 10'd240, 10'd240, 10'd240});
    check("mid_rst_busy", 40'(busy), 40'd0);
    check("mid_rst_done", 40'(update_done), 40'd0);
    check("mid_rst_ovr",  40'(overrun), 40'd0);
    repeat (4) @(negedge clk);

    // Reset wins over a simultaneous frame_start
    @(posedge clk); #1;
    rst = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", 40'(busy), 40'd0);
    @(negedge clk);
    check("rst_prio_busy2", 40'(busy), 40'd0);

    // Key captured at frame_start, later change ignored
    @(posedge clk); #1;
    keycode = 8'h1A; frame_start = 1'b1;
    model_pass(8'h1A);
    push_expected();
    @(posedge clk); #1;
    frame_start = 1'b0; keycode = 8'h16;
    repeat (N + 1) @(posedge clk);
    #1;
    check("w_latched_y0", 40'(sprite_y[9:0]), 40'd239);
    run_pass(8'h04);
    check("a_x0", 40'(sprite_x[9:0]), 40'd79);
    check("a_y0", 40'(sprite_y[9:0]), 40'd239);

    repeat (3) @(posedge clk);
    check("sb_drained", 40'(sbq.size()), 40'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
